// File: rtl/ofdm_rx_output_buffer_if.sv
// Handshake and data bundle between the OFDM demodulator, the output buffer and the frame consumer.
// The master drives din/din_valid/dout_rready/ovf_clr; the slave (buffer) drives the rest.
interface ofdm_rx_output_buffer_if;
    logic         din;
    logic         din_valid;
    logic         din_ready;
    logic [7:0]   wr_pointer;
    logic [223:0] dout;
    logic         dout_valid;
    logic         dout_rready;
    logic         buff_full;
    logic         overflow;
    logic         ovf_clr;

    modport master (
        output din, din_valid, dout_rready, ovf_clr,
        input  din_ready, wr_pointer, dout, dout_valid, buff_full, overflow
    );

    modport slave (
        input  din, din_valid, dout_rready, ovf_clr,
        output din_ready, wr_pointer, dout, dout_valid, buff_full, overflow
    );
endinterface

// File: rtl/ofdm_rx_output_buffer.sv
// Serial-to-224-bit frame assembler; dout_valid rises on the edge accepting bit 223, held until dout_rready.
// Backpressure via din_ready; OFDM_RX_OUTPUT_DOUBLE_BUFFER_EN adds a separate assembly register.
module ofdm_rx_output_buffer (
    input  logic                     clk,
    input  logic                     nreset,
    ofdm_rx_output_buffer_if.slave   bus
);
    localparam logic [7:0] LAST_IDX = 8'd223;

    logic [7:0]   wr_ptr_q, wr_ptr_d;
    logic [223:0] dout_q, dout_d;
    logic         dout_valid_q, dout_valid_d;
    logic         ovf_q, ovf_d;
    logic         din_ready;
    logic         fire;
    logic         last;

    assign fire = bus.din_valid & din_ready;
    assign last = (wr_ptr_q == LAST_IDX);

`ifdef OFDM_RX_OUTPUT_DOUBLE_BUFFER_EN
    logic [223:0] asm_q, asm_d;
    logic         pend_q, pend_d;
    logic         dout_free;

    assign dout_free = ~dout_valid_q | bus.dout_rready;
    assign din_ready = nreset & ~pend_q;

    always_comb begin
        asm_d        = asm_q;
        dout_d       = dout_q;
        pend_d       = pend_q;
        wr_ptr_d     = wr_ptr_q;
        dout_valid_d = dout_valid_q & ~bus.dout_rready;
        if (fire) begin
            asm_d[wr_ptr_q] = bus.din;
        end
        // A pending frame parks wr_pointer at 223 until dout frees up.
        if (pend_q) begin
            if (dout_free) begin
                dout_d       = asm_q;
                dout_valid_d = 1'b1;
                pend_d       = 1'b0;
                wr_ptr_d     = 8'd0;
            end
        end else if (fire && last) begin
            if (dout_free) begin
                dout_d       = asm_d;
                dout_valid_d = 1'b1;
                wr_ptr_d     = 8'd0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (fire) begin
            wr_ptr_d = wr_ptr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            asm_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            pend_q <= pend_d;
        end
    end
`else
    // dout doubles as the assembly register, so filling waits for consumption.
    assign din_ready = nreset & ~dout_valid_q;

    always_comb begin
        dout_d       = dout_q;
        wr_ptr_d     = wr_ptr_q;
        dout_valid_d = dout_valid_q & ~bus.dout_rready;
        if (fire) begin
            dout_d[wr_ptr_q] = bus.din;
            if (last) begin
                wr_ptr_d     = 8'd0;
                dout_valid_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 8'd1;
            end
        end
    end
`endif

    // Set wins over clear so no overflow event is lost.
    always_comb begin
        ovf_d = (bus.din_valid & ~din_ready) | (ovf_q & ~bus.ovf_clr);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q     <= 8'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.wr_pointer = wr_ptr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.buff_full  = dout_valid_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_ofdm_rx_output_buffer.sv
// Directed bench for ofdm_rx_output_buffer; expected frames are built from bit-pattern formulas.
module tb_ofdm_rx_output_buffer;
    logic clk;
    logic nreset;
    int   n_checks;
    int   n_fail;

    ofdm_rx_output_buffer_if bus ();

    ofdm_rx_output_buffer dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [223:0] got, input logic [223:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic pat(input int sel, input int k);
        case (sel)
            0:       pat = (k % 2) == 1;
            1:       pat = (k % 3) == 0;
            2:       pat = ((k * 7) % 11) < 5;
            3:       pat = (k % 5) == 0;
            default: pat = 1'b1;
        endcase
    endfunction

    function automatic logic [223:0] frame(input int sel);
        logic [223:0] f;
        f = '0;
        for (int k = 0; k < 224; k++) f[k] = pat(sel, k);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits(input int sel, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            bus.din       = pat(sel, k);
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
    endtask

    initial begin
        logic [223:0] f_alt;
        n_checks        = 0;
        n_fail          = 0;
        bus.din         = 1'b0;
        bus.din_valid   = 1'b0;
        bus.dout_rready = 1'b0;
        bus.ovf_clr     = 1'b0;
        nreset          = 1'b0;
        #12;
        chk("rst_wr_ptr", 224'(bus.wr_pointer), 224'd0);
        chk("rst_dout", bus.dout, '0);
        chk("rst_dout_valid", 224'(bus.dout_valid), 224'd0);
        chk("rst_buff_full", 224'(bus.buff_full), 224'd0);
        chk("rst_overflow", 224'(bus.overflow), 224'd0);
        chk("rst_din_ready", 224'(bus.din_ready), 224'd0);
        @(negedge clk);
        nreset = 1'b1;
        tick();
        chk("rel_din_ready", 224'(bus.din_ready), 224'd1);

        // Frame 1: alternating bits, expected 0xAAAA...A
        f_alt = {56{4'hA}};
        chk("alt_formula", frame(0), f_alt);
        push_bits(0, 0, 222);
        chk("f1_wr_ptr_222", 224'(bus.wr_pointer), 224'd223);
        chk("f1_not_valid", 224'(bus.dout_valid), 224'd0);
        push_bits(0, 223, 223);
        chk("f1_valid", 224'(bus.dout_valid), 224'd1);
        chk("f1_dout", bus.dout, f_alt);
        chk("f1_wr_ptr_wrap", 224'(bus.wr_pointer), 224'd0);
        chk("f1_buff_full", 224'(bus.buff_full), 224'd1);

        // Frame held with dout_rready low while the source keeps pushing
`ifdef OFDM_RX_OUTPUT_DOUBLE_BUFFER_EN
        push_bits(1, 0, 223);
        chk("hold_din_ready", 224'(bus.din_ready), 224'd0);
        chk("hold_wr_ptr", 224'(bus.wr_pointer), 224'd223);
        chk("hold_ovf_before", 224'(bus.overflow), 224'd0);
        chk("hold_dout", bus.dout, f_alt);
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk("hold_ovf_set", 224'(bus.overflow), 224'd1);
        chk("hold_wr_ptr2", 224'(bus.wr_pointer), 224'd223);
`else
        bus.din_valid = 1'b1;
        #1;
        chk("hold_din_ready", 224'(bus.din_ready), 224'd0);
        tick();
        bus.din_valid = 1'b0;
        chk("hold_ovf_set", 224'(bus.overflow), 224'd1);
        chk("hold_dout", bus.dout, f_alt);
        chk("hold_valid", 224'(bus.dout_valid), 224'd1);
`endif

        // Consume one frame, then clear overflow
        bus.dout_rready = 1'b1;
        tick();
        bus.dout_rready = 1'b0;
`ifdef OFDM_RX_OUTPUT_DOUBLE_BUFFER_EN
        chk("cons_dout_f2", bus.dout, frame(1));
        chk("cons_valid", 224'(bus.dout_valid), 224'd1);
        chk("cons_wr_ptr", 224'(bus.wr_pointer), 224'd0);
`else
        chk("cons_valid", 224'(bus.dout_valid), 224'd0);
`endif
        chk("cons_din_ready", 224'(bus.din_ready), 224'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 224'(bus.overflow), 224'd0);

        // Next frame completes on the same edge the consumer reads
        push_bits(2, 0, 222);
`ifdef OFDM_RX_OUTPUT_DOUBLE_BUFFER_EN
        chk("b2b_prev_dout", bus.dout, frame(1));
`endif
        bus.dout_rready = 1'b1;
        push_bits(2, 223, 223);
        bus.dout_rready = 1'b0;
        chk("b2b_dout", bus.dout, frame(2));
        chk("b2b_valid", 224'(bus.dout_valid), 224'd1);
        chk("b2b_wr_ptr", 224'(bus.wr_pointer), 224'd0);

        // Simultaneous overflow set and clear leaves it set
`ifdef OFDM_RX_OUTPUT_DOUBLE_BUFFER_EN
        push_bits(4, 0, 223);
        chk("pend_din_ready", 224'(bus.din_ready), 224'd0);
`endif
        bus.din_valid = 1'b1;
        bus.ovf_clr   = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        chk("ovf_set_wins", 224'(bus.overflow), 224'd1);
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_clr_alone", 224'(bus.overflow), 224'd0);

        // Drain, then reset in the middle of a frame
        bus.dout_rready = 1'b1;
        tick();
        tick();
        bus.dout_rready = 1'b0;
        chk("drain_valid", 224'(bus.dout_valid), 224'd0);
        push_bits(4, 0, 99);
        chk("mid_wr_ptr", 224'(bus.wr_pointer), 224'd100);
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_wr_ptr", 224'(bus.wr_pointer), 224'd0);
        chk("mid_rst_dout", bus.dout, '0);
        chk("mid_rst_valid", 224'(bus.dout_valid), 224'd0);
        chk("mid_rst_full", 224'(bus.buff_full), 224'd0);
        chk("mid_rst_ovf", 224'(bus.overflow), 224'd0);
        chk("mid_rst_din_ready", 224'(bus.din_ready), 224'd0);
        tick();
        tick();
        nreset = 1'b1;
        tick();
        push_bits(3, 0, 223);
        chk("post_rst_dout", bus.dout, frame(3));
        chk("post_rst_valid", 224'(bus.dout_valid), 224'd1);
        chk("post_rst_wr_ptr", 224'(bus.wr_pointer), 224'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
